// File: rtl/wb_write_arbiter_if.sv
// Bundle of the writeback arbiter's producer, forwarding and register-file write signals.
// "master" is the surrounding pipeline; "slave" is the arbiter itself.
interface wb_write_arbiter_if #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                  alu_valid;
    logic [4:0]            alu_reg;
    logic [DATA_WIDTH-1:0] alu_data;

    logic                  mem_valid;
    logic                  mem_ready;
    logic [4:0]            mem_reg;
    logic [DATA_WIDTH-1:0] mem_data;

    logic [4:0]            fwd_reg1;
    logic [4:0]            fwd_reg2;
    logic                  fwd_hit1;
    logic [DATA_WIDTH-1:0] fwd_data1;
    logic                  fwd_hit2;
    logic [DATA_WIDTH-1:0] fwd_data2;

    logic                  reg_write;
    logic [4:0]            write_register;
    logic [DATA_WIDTH-1:0] write_data;
    logic [CNT_W-1:0]      pending_count;

    modport master (
        output alu_valid, alu_reg, alu_data,
        output mem_valid, mem_reg, mem_data,
        output fwd_reg1, fwd_reg2,
        input  mem_ready, fwd_hit1, fwd_data1, fwd_hit2, fwd_data2,
        input  reg_write, write_register, write_data, pending_count
    );

    modport slave (
        input  alu_valid, alu_reg, alu_data,
        input  mem_valid, mem_reg, mem_data,
        input  fwd_reg1, fwd_reg2,
        output mem_ready, fwd_hit1, fwd_data1, fwd_hit2, fwd_data2,
        output reg_write, write_register, write_data, pending_count
    );
endinterface

// File: rtl/wb_write_arbiter.sv
// Single writer of the register file: ALU results go straight out, loads are queued
// behind them, and a forwarding lookup exposes everything not yet written.
module wb_write_arbiter #(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 64,
    parameter int ZERO_REG   = 31
) (
    input logic              clk,
    input logic              reset,
    wb_write_arbiter_if.slave bus
);
    localparam int         PTR_W = $clog2(DEPTH);
    localparam int         CNT_W = $clog2(DEPTH + 1);
    localparam logic [4:0] ZR    = 5'(ZERO_REG);

    logic [4:0]            q_reg  [DEPTH];
    logic [DATA_WIDTH-1:0] q_data [DEPTH];
    logic [DEPTH-1:0]      q_live;
    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic [CNT_W-1:0]      count;

    logic                  reg_write_q;
    logic [4:0]            wr_reg_q;
    logic [DATA_WIDTH-1:0] wr_data_q;

    logic mem_ready_int;
    logic mem_fire;
    logic alu_wr;
    logic q_empty;
    logic pop;
    logic bypass;
    logic push;
    logic push_live;

    assign mem_ready_int = !reset && (count < CNT_W'(DEPTH));
    assign mem_fire      = bus.mem_valid && mem_ready_int;
    assign alu_wr        = bus.alu_valid && (bus.alu_reg != ZR);
    assign q_empty       = (count == '0);
    assign pop           = !alu_wr && !q_empty;
    assign bypass        = !alu_wr && q_empty && mem_fire && (bus.mem_reg != ZR);
    assign push          = mem_fire && (bus.mem_reg != ZR) && !bypass;
    // A load racing an ALU write to the same register is older, so it lands already dead.
    assign push_live     = !(alu_wr && (bus.mem_reg == bus.alu_reg));

    assign bus.mem_ready      = mem_ready_int;
    assign bus.reg_write      = reg_write_q;
    assign bus.write_register = wr_reg_q;
    assign bus.write_data     = wr_data_q;
    assign bus.pending_count  = count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            q_live      <= '0;
            reg_write_q <= 1'b0;
            wr_reg_q    <= '0;
            wr_data_q   <= '0;
        end else begin
            if (alu_wr) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (q_reg[i] == bus.alu_reg) q_live[i] <= 1'b0;
                end
            end
            if (push) begin
                q_live[tail] <= push_live;
                tail         <= tail + PTR_W'(1);
            end
            if (pop) head <= head + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);

            if (alu_wr) begin
                reg_write_q <= 1'b1;
                wr_reg_q    <= bus.alu_reg;
                wr_data_q   <= bus.alu_data;
            end else if (pop) begin
                reg_write_q <= q_live[head];
                if (q_live[head]) begin
                    wr_reg_q  <= q_reg[head];
                    wr_data_q <= q_data[head];
                end
            end else if (bypass) begin
                reg_write_q <= 1'b1;
                wr_reg_q    <= bus.mem_reg;
                wr_data_q   <= bus.mem_data;
            end else begin
                reg_write_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_reg[tail]  <= bus.mem_reg;
            q_data[tail] <= bus.mem_data;
        end
    end

    // Scan oldest to youngest so the youngest live match overrides; output register is the fallback.
    always_comb begin
        logic [PTR_W-1:0] idx;
        logic             hit1;
        logic             hit2;
        logic [DATA_WIDTH-1:0] data1;
        logic [DATA_WIDTH-1:0] data2;
        hit1  = 1'b0;
        hit2  = 1'b0;
        data1 = '0;
        data2 = '0;
        idx   = '0;
        if (reg_write_q && (wr_reg_q == bus.fwd_reg1)) begin
            hit1  = 1'b1;
            data1 = wr_data_q;
        end
        if (reg_write_q && (wr_reg_q == bus.fwd_reg2)) begin
            hit2  = 1'b1;
            data2 = wr_data_q;
        end
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PTR_W'(k);
            if ((CNT_W'(k) < count) && q_live[idx]) begin
                if (q_reg[idx] == bus.fwd_reg1) begin
                    hit1  = 1'b1;
                    data1 = q_data[idx];
                end
                if (q_reg[idx] == bus.fwd_reg2) begin
                    hit2  = 1'b1;
                    data2 = q_data[idx];
                end
            end
        end
        if (bus.fwd_reg1 == ZR) begin
            hit1  = 1'b0;
            data1 = '0;
        end
        if (bus.fwd_reg2 == ZR) begin
            hit2  = 1'b0;
            data2 = '0;
        end
        bus.fwd_hit1  = hit1;
        bus.fwd_data1 = data1;
        bus.fwd_hit2  = hit2;
        bus.fwd_data2 = data2;
    end
endmodule

// File: tb/tb_wb_write_arbiter.sv
// Randomized and directed bench for wb_write_arbiter with a queue-based reference model
// and a scoreboard of expected register-file writes tagged with their expected cycle.
module tb_wb_write_arbiter;
    localparam int DEPTH = 4;
    localparam int DW    = 64;
    localparam logic [4:0] ZR = 5'd31;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    wb_write_arbiter_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

    wb_write_arbiter #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .ZERO_REG(31)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [4:0]    r;
        logic [DW-1:0] d;
        bit            live;
    } ent_t;

    typedef struct {
        int            cyc;
        logic [4:0]    r;
        logic [DW-1:0] d;
    } exp_t;

    ent_t mq[$];
    exp_t sb[$];
    bit            o_v;
    logic [4:0]    o_r;
    logic [DW-1:0] o_d;

    int errors = 0;
    int checks = 0;
    int edge_cnt = 0;
    int acc_cnt = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic void model_fwd(input logic [4:0] r, output bit hit, output logic [DW-1:0] d);
        hit = 1'b0;
        d   = '0;
        if (r == ZR) return;
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i].live && mq[i].r == r) begin
                hit = 1'b1;
                d   = mq[i].d;
                return;
            end
        end
        if (o_v && o_r == r) begin
            hit = 1'b1;
            d   = o_d;
        end
    endfunction

    // Called at a negedge: drive inputs, check outputs against the model, advance the model one edge.
    task automatic step(input bit av, input logic [4:0] ar, input logic [DW-1:0] ad,
                        input bit mv, input logic [4:0] mr, input logic [DW-1:0] md,
                        input logic [4:0] f1, input logic [4:0] f2);
        bit ready, acc, aw, mw, wr, h1, h2;
        logic [DW-1:0] fd1, fd2;
        logic [4:0] wr_r;
        logic [DW-1:0] wr_d;
        ent_t e;
        bus.alu_valid = av; bus.alu_reg = ar; bus.alu_data = ad;
        bus.mem_valid = mv; bus.mem_reg = mr; bus.mem_data = md;
        bus.fwd_reg1 = f1;  bus.fwd_reg2 = f2;
        #1;
        ready = (mq.size() < DEPTH);
        model_fwd(f1, h1, fd1);
        model_fwd(f2, h2, fd2);
        chk("mem_ready", DW'(bus.mem_ready), DW'(ready));
        chk("pending_count", DW'(bus.pending_count), DW'(mq.size()));
        chk("fwd_hit1", DW'(bus.fwd_hit1), DW'(h1));
        chk("fwd_data1", bus.fwd_data1, fd1);
        chk("fwd_hit2", DW'(bus.fwd_hit2), DW'(h2));
        chk("fwd_data2", bus.fwd_data2, fd2);
        if (mv && bus.mem_ready) acc_cnt++;

        acc = mv && ready;
        aw  = av && (ar != ZR);
        mw  = acc && (mr != ZR);
        wr  = 1'b0;
        wr_r = '0;
        wr_d = '0;
        if (aw) begin
            foreach (mq[i]) if (mq[i].r == ar) mq[i].live = 1'b0;
            wr = 1'b1; wr_r = ar; wr_d = ad;
            if (mw) mq.push_back('{r: mr, d: md, live: (mr != ar)});
        end else if (mq.size() > 0) begin
            e = mq.pop_front();
            wr = e.live; wr_r = e.r; wr_d = e.d;
            if (mw) mq.push_back('{r: mr, d: md, live: 1'b1});
        end else if (mw) begin
            wr = 1'b1; wr_r = mr; wr_d = md;
        end
        o_v = wr;
        if (wr) begin
            o_r = wr_r;
            o_d = wr_d;
            sb.push_back('{cyc: edge_cnt + 1, r: wr_r, d: wr_d});
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    function automatic logic [4:0] rnd_reg();
        int v;
        v = $urandom_range(0, 8);
        return (v == 8) ? ZR : 5'(v);
    endfunction

    // Monitor: every edge, a DUT write must match the oldest expected write, on its cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            edge_cnt++;
            if (bus.reg_write === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_write", DW'(bus.write_register), DW'(0));
                    chk("unexpected_write_en", DW'(bus.reg_write), DW'(0));
                end else begin
                    e = sb.pop_front();
                    chk("write_cycle", DW'(edge_cnt), DW'(e.cyc));
                    chk("write_register", DW'(bus.write_register), DW'(e.r));
                    chk("write_data", bus.write_data, e.d);
                end
            end else if (sb.size() > 0 && sb[0].cyc <= edge_cnt) begin
                e = sb.pop_front();
                chk("missed_write", DW'(bus.reg_write), DW'(1));
            end
        end
    end

    initial begin
        o_v = 1'b0; o_r = '0; o_d = '0;
        bus.alu_valid = 0; bus.alu_reg = 0; bus.alu_data = 0;
        bus.mem_valid = 0; bus.mem_reg = 0; bus.mem_data = 0;
        bus.fwd_reg1 = 0; bus.fwd_reg2 = 0;
        repeat (2) @(negedge clk);
        chk("rst_reg_write", DW'(bus.reg_write), DW'(0));
        chk("rst_write_register", DW'(bus.write_register), DW'(0));
        chk("rst_write_data", bus.write_data, DW'(0));
        chk("rst_pending", DW'(bus.pending_count), DW'(0));
        chk("rst_mem_ready", DW'(bus.mem_ready), DW'(0));
        reset = 1'b0;
        #1;
        chk("rel_mem_ready", DW'(bus.mem_ready), DW'(1));
        @(negedge clk);

        // single bypassed load
        step(0, 0, 0, 1, 5'd5, 64'hAA, 0, 0);
        chk("t2_reg_write", DW'(bus.reg_write), DW'(1));
        chk("t2_write_register", DW'(bus.write_register), DW'(5));
        chk("t2_write_data", bus.write_data, 64'hAA);
        chk("t2_pending", DW'(bus.pending_count), DW'(0));
        idle(2);

        // ALU busy 6 cycles, 5 loads offered: only DEPTH fit
        acc_cnt = 0;
        for (int i = 0; i < 6; i++)
            step(1, 5'(i + 1), 64'h100 + 64'(i), (i < 5), 5'(10 + i), 64'h200 + 64'(i), 5'(10 + i), 5'(i + 1));
        chk("t3_accepted", DW'(acc_cnt), DW'(4));
        idle(6);

        // ALU kills queued load to R7
        step(1, 5'd1, 64'h5, 1, 5'd7, 64'h11, 5'd7, 0);
        step(1, 5'd7, 64'h22, 0, 0, 0, 5'd7, 0);
        step(0, 0, 0, 0, 0, 0, 5'd7, 0);
        chk("t4_dead_pop", DW'(bus.reg_write), DW'(0));
        bus.fwd_reg1 = 5'd7;
        #1;
        chk("t4_fwd_miss", DW'(bus.fwd_hit1), DW'(0));
        idle(2);

        // youngest queued match wins; ZERO_REG never hits
        step(1, 5'd1, 64'h9, 1, 5'd3, 64'h1, 0, 0);
        step(1, 5'd2, 64'h8, 1, 5'd3, 64'h2, 0, 0);
        bus.fwd_reg1 = 5'd3;
        bus.fwd_reg2 = ZR;
        #1;
        chk("t5_hit1", DW'(bus.fwd_hit1), DW'(1));
        chk("t5_data1", bus.fwd_data1, 64'h2);
        chk("t5_hit2", DW'(bus.fwd_hit2), DW'(0));
        chk("t5_data2", bus.fwd_data2, DW'(0));
        step(1, 5'd4, 64'h7, 0, 0, 0, 5'd3, ZR);
        idle(4);

        // zero-register results are swallowed
        step(1, ZR, 64'h33, 1, ZR, 64'h44, ZR, 0);
        chk("t6_reg_write", DW'(bus.reg_write), DW'(0));
        chk("t6_pending", DW'(bus.pending_count), DW'(0));
        idle(1);

        for (int i = 0; i < 400; i++)
            step(($urandom_range(0, 99) < 45), rnd_reg(), {$urandom, $urandom},
                 ($urandom_range(0, 99) < 60), rnd_reg(), {$urandom, $urandom},
                 rnd_reg(), rnd_reg());
        idle(6);

        // reset mid-stream with three queued loads
        for (int i = 0; i < 3; i++)
            step(1, 5'(i + 1), 64'h300 + 64'(i), 1, 5'(20 + i), 64'h400 + 64'(i), 0, 0);
        chk("t1_pre_pending", DW'(bus.pending_count), DW'(3));
        reset = 1'b1;
        #1;
        chk("t1_reg_write", DW'(bus.reg_write), DW'(0));
        chk("t1_pending", DW'(bus.pending_count), DW'(0));
        chk("t1_mem_ready_rst", DW'(bus.mem_ready), DW'(0));
        mq.delete();
        sb.delete();
        o_v = 1'b0; o_r = '0; o_d = '0;
        bus.alu_valid = 0; bus.mem_valid = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("t1_mem_ready_rel", DW'(bus.mem_ready), DW'(1));
        @(negedge clk);

        for (int i = 0; i < 100; i++)
            step(($urandom_range(0, 99) < 50), rnd_reg(), {$urandom, $urandom},
                 ($urandom_range(0, 99) < 70), rnd_reg(), {$urandom, $urandom},
                 rnd_reg(), rnd_reg());
        idle(8);
        chk("sb_drained", DW'(sb.size()), DW'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/wb_write_arbiter.md
Name: wb_write_arbiter

Overview:
- Writeback-side initiator for the 31+1 register file. It is the single driver of the register file write port (reg_write / write_register / write_data).
- Merges two result producers: in-order ALU results, which are never stalled, and memory load results, which are handshaked and buffered in a small queue.
- Exposes a forwarding lookup so decode can see results that are queued or in flight but not yet written.

Parameters:
DEPTH, 4, number of load-result queue entries (power of two, >=2)
DATA_WIDTH, 64, result/data width
ZERO_REG, 31, hardwired-zero register index; writes to it are discarded

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
alu_valid  input  1  ALU result present this cycle (always accepted)
alu_reg  input  5  ALU destination register
alu_data  input  DATA_WIDTH  ALU result
mem_valid  input  1  load result offered
mem_ready  output  1  load result accepted when mem_valid&mem_ready
mem_reg  input  5  load destination register
mem_data  input  DATA_WIDTH  load result
fwd_reg1  input  5  forwarding lookup address, read port 1
fwd_reg2  input  5  forwarding lookup address, read port 2
fwd_hit1  output  1  pending value exists for fwd_reg1
fwd_data1  output  DATA_WIDTH  pending value for fwd_reg1
fwd_hit2  output  1  pending value exists for fwd_reg2
fwd_data2  output  DATA_WIDTH  pending value for fwd_reg2
reg_write  output  1  register file write enable (registered)
write_register  output  5  register file write address (registered)
write_data  output  DATA_WIDTH  register file write data (registered)
pending_count  output  $clog2(DEPTH+1)  occupied queue slots, including killed entries

Behaviour:

Reset (asynchronous):
- Queue is emptied and all entry-valid bits are cleared.
- reg_write=0, write_register=0, write_data=0, pending_count=0.
- mem_ready=0 while reset is high.

Readiness:
- mem_ready = (pending_count < DEPTH), derived from registered state only.
- When the queue is full, no enqueue is accepted, even in a cycle that pops.

Output register update, at each edge, first matching rule wins:
1. alu_valid and alu_reg != ZERO_REG: load the ALU result, reg_write<=1.
2. Queue non-empty: pop the head. If the head is live, reg_write<=1 with its reg/data; if it was killed, reg_write<=0.
3. Queue empty, mem handshake, and mem_reg != ZERO_REG: bypass the load into the output register, reg_write<=1.
4. Otherwise reg_write<=0. write_register and write_data hold their previous values.

Latency:
- An accepted result drives reg_write exactly 1 cycle later when it bypasses the queue.
- A queued load waits behind older queued loads and any ALU results.

Enqueue:
- A mem handshake that is not bypassed and has mem_reg != ZERO_REG pushes at the tail, live.
- Results targeting ZERO_REG (ALU or mem) are accepted and dropped: no queue slot is used and no write occurs.

Ordering and kill:
- ALU results are always younger than all queued loads and any simultaneous mem result.
- An ALU accept with reg R clears the live bit of every queued entry with reg R.
- A same-cycle mem result with reg R is also accepted but never written.
- Killed entries keep their slot until popped.

Forwarding (combinational):
- Lookup targets are the live queue entries and the output register while reg_write=1.
- Priority: the youngest live queue match wins, then the output register.
- fwd_reg == ZERO_REG never hits. On a miss, fwd_data=0.
- Current-cycle alu_*/mem_* inputs are not forwarded.

Pointers and count:
- Head and tail pointers wrap modulo DEPTH.
- pending_count changes by +1 on push, -1 on pop, and stays the same on simultaneous push+pop.

Reset mid-operation: all queued entries are lost, and reg_write is forced to 0 immediately.

Test Plan:
1. Reset asserted mid-stream with 3 queued loads -> reg_write=0 and pending_count=0 at once; mem_ready=1 on the first cycle after release.
2. Single load (mem_reg=5, data=0xAA) with an idle ALU -> next cycle reg_write=1, write_register=5, write_data=0xAA; queue stays empty.
3. ALU busy for 6 cycles while 5 loads are offered (DEPTH=4) -> 4 accepted, mem_ready=0 on the 5th. After the ALU idles, loads are written in order one per cycle, and mem_ready rises after the first pop.
4. Queue holds a load to R7 = 0x11 and ALU writes R7 = 0x22 -> the ALU write occurs, the later pop of the R7 entry gives reg_write=0, and fwd on R7 misses once the ALU write has retired.
5. Queue holds R3=0x1 (older) and R3=0x2 (younger); fwd_reg1=3 -> fwd_hit1=1, fwd_data1=0x2. fwd_reg2=31 -> fwd_hit2=0, fwd_data2=0.
6. ALU writes R31 and a load to R31 is offered -> no reg_write, pending_count unchanged, mem handshake completes.
